if_fetch_queue: RTL and testbench

- Small synchronous FIFO between the instruction fetch stage and the decode stage.
- Buffers fetched (pc, instruction) pairs so that a decode stall does not immediately freeze the PC register.
- The fetch stage pushes when not frozen. Its freeze input is driven by ~in_ready (OR'd with hazard freeze externally).
- Decode pops when it can accept. A taken branch flushes every buffered entry.

---
 rtl/if_fetch_queue.sv | 95 +++++++++
 tb/tb_if_fetch_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: small synchronous FIFO of (pc, instruction) pairs placed
// between fetch and decode. A decode stall fills the queue before the fetch
// stage has to freeze its PC; a taken branch empties it in one cycle.
// Full and empty are told apart by the occupancy count, so both pointers may
// be equal in either state.
module if_fetch_queue #(
    parameter  int ADDRESS_LEN = 32,
    parameter  int DEPTH       = 4,
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [ADDRESS_LEN-1:0] in_pc,
    input  logic [ADDRESS_LEN-1:0] in_instruction,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [ADDRESS_LEN-1:0] out_pc,
    output logic [ADDRESS_LEN-1:0] out_instruction,
    input  logic                   out_ready,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [2*ADDRESS_LEN-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W:0]           r_count;

    logic                     w_not_full;
    logic                     w_not_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [2*ADDRESS_LEN-1:0] w_head;

    assign w_not_full  = (r_count != FULL_COUNT);
    assign w_not_empty = (r_count != '0);

    // A flush cancels both handshakes; a push while full is dropped even if
    // the head is popped in the same cycle, since there is no write-through.
    assign w_push = in_valid  & w_not_full  & ~flush;
    assign w_pop  = out_ready & w_not_empty & ~flush;

    assign w_head = r_mem[r_rd_ptr];

    assign in_ready  = w_not_full;
    assign out_valid = w_not_empty;
    assign count     = r_count;

    // Head outputs read as zero when empty so decode sees a NOP bubble.
    always_comb begin
        out_pc          = '0;
        out_instruction = '0;
        if (w_not_empty) begin
            out_pc          = w_head[2*ADDRESS_LEN-1:ADDRESS_LEN];
            out_instruction = w_head[ADDRESS_LEN-1:0];
        end
    end

    // Storage write on an accepted push; contents need no reset because the
    // head is only exposed while the count says it is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instruction};
        end
    end

    // Pointer and occupancy update; reset wins over flush, flush over traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios followed by a randomized run,
// all checked against a queue-based reference model of the FIFO behaviour.
module tb_if_fetch_queue;

    localparam int AL    = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [AL-1:0]     in_pc;
    logic [AL-1:0]     in_instruction;
    logic              in_ready;
    logic              out_valid;
    logic [AL-1:0]     out_pc;
    logic [AL-1:0]     out_instruction;
    logic              out_ready;
    logic [PTR_W:0]    count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: the queue holds {pc, instruction}, oldest at index 0.
    logic [2*AL-1:0] model_q[$];

    if_fetch_queue #(
        .ADDRESS_LEN(AL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instruction (in_instruction),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .out_ready      (out_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against what the model queue implies.
    task automatic check_model(input string tag);
        logic [63:0] exp_pc;
        logic [63:0] exp_ins;
        exp_pc  = '0;
        exp_ins = '0;
        if (model_q.size() != 0) begin
            exp_pc  = 64'(model_q[0][2*AL-1:AL]);
            exp_ins = 64'(model_q[0][AL-1:0]);
        end
        chk({tag, ".count"},     64'(count),     64'(model_q.size()));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
        chk({tag, ".out_pc"},    64'(out_pc),    exp_pc);
        chk({tag, ".out_ins"},   64'(out_instruction), exp_ins);
    endtask

    // Drive one cycle of inputs, advance the model by the FIFO rules, clock,
    // then check the outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic f, input logic iv,
                        input logic [AL-1:0] pc, input logic [AL-1:0] ins, input logic ordy);
        bit do_push;
        bit do_pop;
        rst            = r;
        flush          = f;
        in_valid       = iv;
        in_pc          = pc;
        in_instruction = ins;
        out_ready      = ordy;
        if (!r || f) begin
            model_q.delete();
        end else begin
            do_push = iv   && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AL-1:0] pc_n;

        // Reset held two cycles with a push pending, then released idle.
        step("rst0", 1'b0, 1'b0, 1'b1, 32'h4, 32'h1, 1'b0);
        step("rst1", 1'b0, 1'b0, 1'b1, 32'h4, 32'h1, 1'b0);
        step("rst_rel", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("rst_rel.pc_zero", 64'(out_pc), 64'h0);

        // Fill to capacity in order, then an ignored fifth push.
        for (int i = 1; i <= 4; i++) begin
            step("fill", 1'b1, 1'b0, 1'b1, AL'(4 * i), 32'hE3A0_0000 + AL'(i), 1'b0);
        end
        chk("fill.count4", 64'(count), 64'd4);
        chk("fill.not_ready", 64'(in_ready), 64'd0);
        step("fill_5th", 1'b1, 1'b0, 1'b1, 32'd20, 32'hE3A0_0005, 1'b0);
        chk("fill_5th.head", 64'(out_pc), 64'd4);

        // Drain: heads 8,12,16 follow, then empty bubble.
        for (int i = 0; i < 5; i++) begin
            step("drain", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        end
        chk("drain.empty", 64'(out_valid), 64'd0);

        // Steady state at count 2 with simultaneous push/pop, wrapping pointers.
        step("ss_pre", 1'b1, 1'b0, 1'b1, 32'h24, 32'hA0, 1'b0);
        step("ss_pre", 1'b1, 1'b0, 1'b1, 32'h28, 32'hA1, 1'b0);
        pc_n = 32'h2C;
        for (int i = 0; i < 6; i++) begin
            step("steady", 1'b1, 1'b0, 1'b1, pc_n, 32'hB0 + AL'(i), 1'b1);
            chk("steady.head_pc", 64'(out_pc), 64'(32'h28 + AL'(4 * i)));
            pc_n = pc_n + 32'd4;
        end

        // Full with pop: push rejected, then accepted next cycle.
        step("full_pre", 1'b1, 1'b0, 1'b1, 32'h44, 32'hC0, 1'b0);
        step("full_pre", 1'b1, 1'b0, 1'b1, 32'h48, 32'hC1, 1'b0);
        step("full_pop", 1'b1, 1'b0, 1'b1, 32'h4C, 32'hC2, 1'b1);
        chk("full_pop.count3", 64'(count), 64'd3);
        step("full_retry", 1'b1, 1'b0, 1'b1, 32'h4C, 32'hC2, 1'b0);
        chk("full_retry.count4", 64'(count), 64'd4);

        // Flush at count 3 with concurrent push and pop.
        step("fl_pre", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        step("flush", 1'b1, 1'b1, 1'b1, 32'h100, 32'hD0, 1'b1);
        chk("flush.count0", 64'(count), 64'd0);
        step("fl_push", 1'b1, 1'b0, 1'b1, 32'h200, 32'hD1, 1'b0);
        chk("fl_push.head", 64'(out_pc), 64'h200);

        // Reset mid-operation at count 2, with flush and push also asserted.
        step("mr_pre", 1'b1, 1'b0, 1'b1, 32'h204, 32'hD2, 1'b0);
        step("mid_rst", 1'b0, 1'b1, 1'b1, 32'h300, 32'hD3, 1'b1);
        chk("mid_rst.valid", 64'(out_valid), 64'd0);
        step("mr_push", 1'b1, 1'b0, 1'b1, 32'h40, 32'hD4, 1'b0);
        step("mr_drain", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        step("mr_drain", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            step("rand",
                 ($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 24) == 0),
                 1'($urandom),
                 AL'($urandom), AL'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
